pwm_blink_sequencer: RTL
========================

# pwm_blink_sequencer

Sequencer that drives the PWM datapath through a programmable blink pattern. It holds a small table of (duty, hold) entries written by the host-side register interface. It steps through those entries using the 2 kHz square wave from the clock divider as its time base, and presents the current duty command and enable to the PWM generator. All logic runs in the clk_30MHz domain.

## Interface
- DUTY_W, 8, width of duty command
- HOLD_W, 16, width of per-entry hold count, in 2 kHz ticks (0.5 ms units)
- DEPTH, 8, number of pattern entries; power of two, ≥2; AW = $clog2(DEPTH)

- clk_30MHz  in  1  system clock
- reset  in  1  asynchronous, active-high
- clk_2kHz  in  1  2 kHz square wave from divider; treated as asynchronous data
- cfg_we  in  1  table write strobe
- cfg_addr  in  AW  table write address
- cfg_duty  in  DUTY_W  duty value for written entry
- cfg_hold  in  HOLD_W  hold count for written entry
- cfg_last  in  AW  index of last active entry; sampled on accepted start
- loop_en  in  1  1 = wrap to entry 0 after cfg_last; sampled on accepted start
- start  in  1  begin pattern (single-cycle pulse or level)
- stop  in  1  abort pattern
- duty  out  DUTY_W  duty command to PWM generator
- pwm_en  out  1  PWM output enable
- busy  out  1  high in any state except IDLE
- step_idx  out  AW  index of the entry currently playing
- done  out  1  one-cycle pulse on natural completion

## Operation
- Tick: clk_2kHz passes through a 2-FF synchronizer plus an edge register; tick = rising edge, exactly one clk_30MHz cycle wide.
- Table: DEPTH × (DUTY_W+HOLD_W) registers, written on cfg_we in any state. A write and a LOAD of the same address in the same cycle: LOAD sees the old value.
- FSM:
  - IDLE: duty=0, pwm_en=0. start && !stop → LOAD, idx=0, latch cfg_last/loop_en.
  - LOAD (1 cycle): hold_cnt ← max(table[idx].hold,1); duty ← table[idx].duty; pwm_en=1 → RUN.
  - RUN: on tick: if hold_cnt>1, decrement. Else, if idx≠last_q, idx+1 → LOAD; else if loop_q, idx=0 → LOAD; else → FINISH.
  - FINISH (1 cycle): done=1, duty←0, pwm_en←0 → IDLE.
- stop in LOAD/RUN/FINISH → IDLE next cycle, duty←0, pwm_en←0, no done. stop wins over simultaneous start. start while busy is ignored.
- hold=0 is treated as 1 tick.
- step_idx follows idx and is 0 in IDLE.

## Timing
- Reset values: duty=0, pwm_en=0, busy=0, step_idx=0, done=0, FSM=IDLE, sync flops=0. If clk_2kHz is high at reset release, one tick is produced; this is permitted.
- start sampled at edge N → LOAD in cycle N+1 → duty/pwm_en valid from edge N+2.
- clk_2kHz rising edge → tick 2–3 cycles later.
- An entry with hold H plays for between H−1 and H tick periods. The entry-to-entry gap is one LOAD cycle, during which duty holds the previous value.
- tick coincident with stop: stop wins.

## Configuration
- PWM_SEQ_RAMP_EN defined: LOAD updates an internal target only. On each tick, duty moves 1 LSB toward the target until equal; ramping runs concurrently with hold_cnt. FINISH and stop still force duty=0 immediately.
- Not defined: duty jumps to table value in LOAD; no target register.

## Structure
- Shared package: FSM state enum (IDLE, LOAD, RUN, FINISH), default DUTY_W/HOLD_W/DEPTH constants, and a table-entry struct {duty, hold}.
- One sub-module: pwm_tick_sync (2-FF synchronizer + rising-edge detector, outputs tick). Reused by other 2 kHz consumers.

## Test plan
- Reset mid-RUN (entry 1 playing, duty=0x40) → all outputs return to reset values asynchronously; next start begins at entry 0.
- Table {0:(0xFF,4),1:(0x20,2)}, last=1, loop=0, start → duty 0xFF for 3–4 ticks, then 0x20 for 1–2 ticks; done pulses once; pwm_en=0, busy=0 afterward.
- Same table with loop=1 → step_idx sequence 0,1,0,1,…; no done. stop → pwm_en=0 and duty=0 the next cycle; no done.
- Entry hold=0 → plays for one tick. start+stop same cycle in IDLE → remains IDLE. start while busy → no restart; step_idx unchanged.
- cfg_we to addr 1 while entry 0 plays, changing duty to 0x80 → entry 1 plays 0x80. Write coincident with LOAD of the same address → old value is used.
- With PWM_SEQ_RAMP_EN: entry 0x00→0x04 → duty reads 1,2,3,4 on successive ticks; stop mid-ramp → duty=0 the next cycle.

Source files
------------

// File: rtl/pwm_blink_sequencer_pkg.sv
// pwm_blink_sequencer_pkg
// Shared types and default sizing for the PWM blink sequencer and its users.
//   DUTY_W_DEF / HOLD_W_DEF / DEPTH_DEF : default duty width, hold width, table depth
//   seq_state_t                         : sequencer FSM states
//   seq_entry_t                         : one pattern entry at the default widths
`timescale 1ns/1ps
package pwm_blink_sequencer_pkg;

  localparam int DUTY_W_DEF = 8;
  localparam int HOLD_W_DEF = 16;
  localparam int DEPTH_DEF  = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_FINISH
  } seq_state_t;

  typedef struct packed {
    logic [DUTY_W_DEF-1:0] duty;
    logic [HOLD_W_DEF-1:0] hold;
  } seq_entry_t;

endpackage

// File: rtl/pwm_tick_sync.sv
// pwm_tick_sync
// Brings the free-running 2 kHz square wave into the clk_30MHz domain and turns
// each rising edge into a single-cycle tick.
//   clk_30MHz in  system clock
//   reset     in  asynchronous, active-high
//   clk_2kHz  in  2 kHz square wave, asynchronous to clk_30MHz
//   tick      out one clk_30MHz cycle high per rising edge of clk_2kHz
`timescale 1ns/1ps
module pwm_tick_sync (
  input  logic clk_30MHz,
  input  logic reset,
  input  logic clk_2kHz,
  output logic tick
);

  logic sync1_reg;
  logic sync2_reg;
  logic prev_reg;

  always_ff @(posedge clk_30MHz or posedge reset) begin
    if (reset) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      prev_reg  <= 1'b0;
    end else begin
      sync1_reg <= clk_2kHz;
      sync2_reg <= sync1_reg;
      prev_reg  <= sync2_reg;
    end
  end

  // Only the second synchronizer stage is trusted; prev_reg is the edge register.
  assign tick = sync2_reg & ~prev_reg;

endmodule

// File: rtl/pwm_blink_sequencer.sv
// pwm_blink_sequencer
// Steps through a host-written table of (duty, hold) entries, one 2 kHz tick at a
// time, and drives the duty command / enable of the PWM generator.
// Optional feature macro: PWM_SEQ_RAMP_EN -- when defined, LOAD sets a target and
// duty slews 1 LSB per tick toward it; otherwise duty jumps in LOAD.
// Ports:
//   clk_30MHz, reset (async, active-high)
//   clk_2kHz             2 kHz time base (asynchronous)
//   cfg_we/addr/duty/hold table write port, accepted in any state
//   cfg_last, loop_en    last active entry and wrap enable, captured on start
//   start, stop          begin / abort pattern (stop has priority)
//   duty, pwm_en         command to PWM generator
//   busy, step_idx, done status (done pulses once on natural completion)
`timescale 1ns/1ps
module pwm_blink_sequencer
  import pwm_blink_sequencer_pkg::*;
#(
  parameter int DUTY_W = DUTY_W_DEF,
  parameter int HOLD_W = HOLD_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk_30MHz,
  input  logic              reset,
  input  logic              clk_2kHz,
  input  logic              cfg_we,
  input  logic [AW-1:0]     cfg_addr,
  input  logic [DUTY_W-1:0] cfg_duty,
  input  logic [HOLD_W-1:0] cfg_hold,
  input  logic [AW-1:0]     cfg_last,
  input  logic              loop_en,
  input  logic              start,
  input  logic              stop,
  output logic [DUTY_W-1:0] duty,
  output logic              pwm_en,
  output logic              busy,
  output logic [AW-1:0]     step_idx,
  output logic              done
);

  // Same layout as seq_entry_t, but sized by this instance's parameters.
  typedef struct packed {
    logic [DUTY_W-1:0] duty;
    logic [HOLD_W-1:0] hold;
  } entry_t;

  logic tick;

  pwm_tick_sync u_tick_sync (
    .clk_30MHz (clk_30MHz),
    .reset     (reset),
    .clk_2kHz  (clk_2kHz),
    .tick      (tick)
  );

  // ---------------------------------------------------------------- table
  // Plain registers, not reset. Reads are combinational, so a LOAD in the same
  // cycle as a write to that entry naturally sees the pre-write contents.
  entry_t table_rd [DEPTH];

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_tbl
    entry_t ent_reg;

    always_ff @(posedge clk_30MHz) begin
      if (cfg_we && (cfg_addr == AW'(gi))) begin
        ent_reg <= '{duty: cfg_duty, hold: cfg_hold};
      end
    end

    assign table_rd[gi] = ent_reg;
  end

  // ---------------------------------------------------------------- FSM
  seq_state_t        state_reg, state_next;
  logic [AW-1:0]     idx_reg, idx_next;
  logic [AW-1:0]     last_reg, last_next;
  logic              loop_reg, loop_next;
  logic [HOLD_W-1:0] hold_reg, hold_next;
  logic [DUTY_W-1:0] duty_reg, duty_next;
  logic              pwm_en_reg, pwm_en_next;
`ifdef PWM_SEQ_RAMP_EN
  logic [DUTY_W-1:0] target_reg, target_next;
`endif

  entry_t ld_entry;
  assign ld_entry = table_rd[idx_reg];

  always_ff @(posedge clk_30MHz or posedge reset) begin
    if (reset) begin
      state_reg  <= ST_IDLE;
      idx_reg    <= '0;
      last_reg   <= '0;
      loop_reg   <= 1'b0;
      hold_reg   <= '0;
      duty_reg   <= '0;
      pwm_en_reg <= 1'b0;
`ifdef PWM_SEQ_RAMP_EN
      target_reg <= '0;
`endif
    end else begin
      state_reg  <= state_next;
      idx_reg    <= idx_next;
      last_reg   <= last_next;
      loop_reg   <= loop_next;
      hold_reg   <= hold_next;
      duty_reg   <= duty_next;
      pwm_en_reg <= pwm_en_next;
`ifdef PWM_SEQ_RAMP_EN
      target_reg <= target_next;
`endif
    end
  end

  always_comb begin
    state_next  = state_reg;
    idx_next    = idx_reg;
    last_next   = last_reg;
    loop_next   = loop_reg;
    hold_next   = hold_reg;
    duty_next   = duty_reg;
    pwm_en_next = pwm_en_reg;
`ifdef PWM_SEQ_RAMP_EN
    target_next = target_reg;
`endif

    unique case (state_reg)
      ST_IDLE: begin
        if (start && !stop) begin
          state_next = ST_LOAD;
          idx_next   = '0;
          last_next  = cfg_last;
          loop_next  = loop_en;
        end
      end

      ST_LOAD: begin
        if (stop) begin
          state_next  = ST_IDLE;
          idx_next    = '0;
          duty_next   = '0;
          pwm_en_next = 1'b0;
        end else begin
          // A zero hold would never expire under the ">1" test, so floor it at 1.
          hold_next   = (ld_entry.hold == '0) ? HOLD_W'(1) : ld_entry.hold;
`ifdef PWM_SEQ_RAMP_EN
          target_next = ld_entry.duty;
`else
          duty_next   = ld_entry.duty;
`endif
          pwm_en_next = 1'b1;
          state_next  = ST_RUN;
        end
      end

      ST_RUN: begin
        if (stop) begin
          state_next  = ST_IDLE;
          idx_next    = '0;
          duty_next   = '0;
          pwm_en_next = 1'b0;
        end else if (tick) begin
          if (hold_reg > HOLD_W'(1)) begin
            hold_next = hold_reg - HOLD_W'(1);
          end else if (idx_reg != last_reg) begin
            idx_next   = idx_reg + AW'(1);
            state_next = ST_LOAD;
          end else if (loop_reg) begin
            idx_next   = '0;
            state_next = ST_LOAD;
          end else begin
            state_next  = ST_FINISH;
            duty_next   = '0;
            pwm_en_next = 1'b0;
          end
`ifdef PWM_SEQ_RAMP_EN
          // Slew toward the target on every tick, independent of the hold count.
          if (state_next != ST_FINISH) begin
            if (duty_reg < target_reg) begin
              duty_next = duty_reg + DUTY_W'(1);
            end else if (duty_reg > target_reg) begin
              duty_next = duty_reg - DUTY_W'(1);
            end
          end
`endif
        end
      end

      ST_FINISH: begin
        state_next  = ST_IDLE;
        idx_next    = '0;
        duty_next   = '0;
        pwm_en_next = 1'b0;
      end

      default: begin
        state_next  = ST_IDLE;
        idx_next    = '0;
        duty_next   = '0;
        pwm_en_next = 1'b0;
      end
    endcase
  end

  assign duty     = duty_reg;
  assign pwm_en   = pwm_en_reg;
  assign busy     = (state_reg != ST_IDLE);
  assign step_idx = idx_reg;
  assign done     = (state_reg == ST_FINISH);

endmodule
